// File: rtl/btb_pkg.sv
// btb_pkg: shared types and constants for the branch target buffer.
package btb_pkg;
    localparam int TAG_W  = 20;
    localparam int BIAS_W = 32;
    typedef struct packed {
        logic              inv;
        logic [TAG_W-1:0]  tag;
        logic [BIAS_W-1:0] bias;
    } btb_entry_t;
    localparam logic [BIAS_W-1:0] BTB_NOT_TAKEN_BIAS = 32'd4;
    localparam logic [1:0]        CONF_MAX           = 2'd3;
    localparam logic [1:0]        CONF_INIT          = 2'd1;
endpackage

// File: rtl/btb_victim_select.sv
// btb_victim_select: picks the lowest invalid entry, else the round-robin pointer.
module btb_victim_select #(
    parameter int ENTRIES = 8,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] inv,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      victim,
    output logic               use_rr
);
    always_comb begin
        victim = rr_ptr;
        use_rr = ~|inv;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (inv[i]) victim = IW'(i);
    end
endmodule

// File: rtl/btb_manager.sv
// btb_manager: branch target buffer with mispredict updates, confidence hysteresis and flush.
module btb_manager
    import btb_pkg::*;
#(
    parameter int ENTRIES = 8,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst,
    output btb_entry_t [ENTRIES-1:0]  predictor,
    input  logic                      update_predictor,
    input  btb_entry_t                update_val,
    input  logic                      correct_valid,
    input  logic [TAG_W-1:0]          correct_tag,
    input  logic                      flush,
    output logic [IW-1:0]             update_adr,
    output logic                      update_hit
);
    logic [ENTRIES-1:0][1:0] conf;
    logic [ENTRIES-1:0]      inv_vec, upd_hits, cor_hits;
    logic [IW-1:0]           rr_ptr, hit_idx, cor_idx, victim;
    logic                    use_rr, cor_hit, not_taken, same_entry;

    btb_victim_select #(.ENTRIES(ENTRIES)) u_victim (
        .inv    (inv_vec),
        .rr_ptr (rr_ptr),
        .victim (victim),
        .use_rr (use_rr)
    );

    always_comb begin
        hit_idx = '0;
        cor_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            inv_vec[i]  = predictor[i].inv;
            upd_hits[i] = !predictor[i].inv && predictor[i].tag == update_val.tag;
            cor_hits[i] = !predictor[i].inv && predictor[i].tag == correct_tag;
            if (upd_hits[i]) hit_idx = IW'(i);
            if (cor_hits[i]) cor_idx = IW'(i);
        end
    end

    assign update_hit = |upd_hits;
    assign cor_hit    = correct_valid && |cor_hits;
    assign not_taken  = update_val.bias == BTB_NOT_TAKEN_BIAS;
    assign same_entry = update_predictor && update_hit && cor_idx == hit_idx;
    assign update_adr = !update_predictor ? '0 : update_hit ? hit_idx : victim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                predictor[i] <= {1'b1, {(TAG_W + BIAS_W){1'b0}}};
            conf   <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++)
                predictor[i].inv <= 1'b1;
            conf <= '0;
        end else begin
            // an update to the same entry takes precedence over a confirm
            if (cor_hit && !same_entry && conf[cor_idx] != CONF_MAX)
                conf[cor_idx] <= conf[cor_idx] + 2'd1;
            if (update_predictor && update_hit) begin
                if (not_taken) begin
                    predictor[hit_idx].inv <= 1'b1;
                    conf[hit_idx]          <= '0;
                end else if (conf[hit_idx] >= 2'd2) begin
                    conf[hit_idx] <= conf[hit_idx] - 2'd1;
                end else begin
                    predictor[hit_idx].bias <= update_val.bias;
                    conf[hit_idx]           <= CONF_INIT;
                end
            end else if (update_predictor && !not_taken) begin
                predictor[victim] <= {1'b0, update_val.tag, update_val.bias};
                conf[victim]      <= CONF_INIT;
                if (use_rr) rr_ptr <= rr_ptr + IW'(1);
            end
        end
    end

    always_ff @(posedge clk)
        if (!rst && update_predictor) assert ($onehot0(upd_hits));
endmodule

// File: doc/btb_manager.md
Name: btb_manager

Overview:
- Owns the branch target buffer consumed by the PC controller. It holds ENTRIES packed predictor entries and drives them continuously to the PC controller's predictor input.
- Applies mispredict updates from ID using tag-hit detection, 2-bit confidence hysteresis and victim selection (first invalid entry, else round-robin).
- Bulk-invalidates the table on flush (fence.i, trap, satp change).

Parameters:
ENTRIES, 8, number of BTB entries; power of two.
TAG_W, 20, tag width; tag = pc[21:2].
BIAS_W, 32, predicted PC increment width.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
predictor  output  [ENTRIES][1+TAG_W+BIAS_W]  entry e = {inv, tag, bias}; inv=1 means empty
update_predictor  input  1  mispredict write request from PC controller
update_val  input  1+TAG_W+BIAS_W  {inv(ignored), tag, correct bias}
correct_valid  input  1  ID confirmed a BTB-predicted branch as correct
correct_tag  input  TAG_W  tag of the confirmed branch
flush  input  1  invalidate all entries
update_adr  output  $clog2(ENTRIES)  index written (hit index or victim) on the current update; combinational
update_hit  output  1  current update_tag matches a valid entry; combinational

Behaviour:
- Reset (async): every entry = {inv=1, tag=0, bias=0}; all conf=0; rr_ptr=0. update_adr and update_hit follow their inputs combinationally.
- State per entry: 53-bit predictor word and a 2-bit conf counter. Global state: rr_ptr, $clog2(ENTRIES) bits.
- All writes are registered. A change is visible on predictor the cycle after the request is sampled. No reads are registered.
- Hit means inv==0 and tag==update tag. Tags are unique, so at most one entry hits; multiple matches are an assertion failure.
- Update with bias == 4 (not-taken default):
  - Hit: set inv=1 and conf=0 on that entry.
  - Miss: no write and no rr_ptr change.
- Update with bias != 4, hit:
  - conf>=2: conf-=1; bias unchanged.
  - conf<2: bias=new value, conf=1.
- Update with bias != 4, miss (allocate):
  - Victim = lowest-index entry with inv=1. If there is none, victim = rr_ptr and rr_ptr increments mod ENTRIES.
  - Write {0, tag, bias} and set conf=1.
  - rr_ptr does not advance when an invalid slot is used.
- Correct confirm:
  - correct_valid with a hit on correct_tag: conf = min(conf+1, 3).
  - Miss: ignored.
- Simultaneous events:
  - flush overrides everything in that cycle: all inv=1, all conf=0, rr_ptr unchanged. Update and confirm are dropped.
  - Update and confirm on the same entry: only the update applies.
  - Update and confirm on different entries: both apply.
- update_adr reports the hit index or the victim regardless of the bias==4 rule; it is 0 when update_predictor=0.
- Bias is stored verbatim with no width arithmetic. Tag compare is exactly TAG_W bits.
- Reset asserted mid-operation clears state immediately. A pending update in that cycle is lost.

Decomposition:
- Package btb_pkg holds:
  - btb_entry_t: packed struct {logic inv; logic [TAG_W-1:0] tag; logic [BIAS_W-1:0] bias;}
  - BTB_NOT_TAKEN_BIAS = 32'd4
  - CONF_MAX = 2'd3
  - CONF_INIT = 2'd1
- Sub-module btb_victim_select: combinational. Inputs are the inv vector and rr_ptr. Outputs are victim index and use_rr. It has no state.

Test Plan:
- Reset, then update {tag=0x00010, bias=0x40} -> next cycle entry0={0,0x00010,0x40}, conf0=1, update_adr=0, rr_ptr=0.
- Fill all 8 entries with tags 1..8, then update tag 9 bias 0x80 -> update_adr=0 (rr_ptr), entry0 tag=9, rr_ptr=1. Update tag 10 -> entry1 replaced, rr_ptr=2.
- Tag 5 in entry4 with conf=1: two correct_valid on tag 5 -> conf=3. Mispredict update bias 0x20 -> bias unchanged, conf=2. Second update -> conf=1, bias unchanged. Third update -> bias=0x20, conf=1.
- Update tag 3 (hit) with bias 4 -> entry inv=1. Next update with new tag 0x7 -> allocated into that freed index, rr_ptr unchanged. Update with new tag bias 4 -> no state change.
- flush asserted in the same cycle as update_predictor and correct_valid -> all inv=1, all conf=0, no write, rr_ptr preserved.
- Assert rst mid-stream while update_predictor=1 -> all entries read {1,0,0} immediately without waiting for a clk edge. After release, the first update allocates index 0.
